// File: rtl/drive_ramp_gen.sv
// Amplitude-envelope generator: latches an I/Q setpoint on trigger and scales it by
// a gain k that ramps 0 -> 1.0, holds, then ramps back to 0 (abort / re-trigger aware).
module drive_ramp_gen #(
  parameter int DW = 17,
  parameter int CW = 20
) (
  input  logic                 adc_clk,
  input  logic                 rst,
  input  logic                 trig,
  input  logic                 abort,
  input  logic signed [DW-1:0] set_i,
  input  logic signed [DW-1:0] set_q,
  input  logic [15:0]          step,
  input  logic [CW-1:0]        hold_len,
  output logic signed [DW-1:0] drive_i,
  output logic signed [DW-1:0] drive_q,
  output logic [1:0]           state,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_FLAT = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam int PW = DW + 18;
  localparam logic [16:0] K_ONE = 17'd65536;

  state_t                state_q, state_d;
  logic [16:0]           k_q, k_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [DW-1:0]  lat_i_q, lat_i_d, lat_q_q, lat_q_d;
  logic signed [PW-1:0]  p_i_q, p_i_d, p_q_q, p_q_d;
  logic signed [DW-1:0]  drive_i_q, drive_i_d, drive_q_q, drive_q_d;
  logic                  done_q, done_d;

  logic [16:0] s;
  logic [17:0] k_up;
  logic [16:0] k_up_sat, k_dn_sat;
  logic        accept;

  always_comb begin
    s        = (step == 16'd0) ? 17'd1 : {1'b0, step};
    k_up     = {1'b0, k_q} + {1'b0, s};
    k_up_sat = (k_up >= {1'b0, K_ONE}) ? K_ONE : k_up[16:0];
    k_dn_sat = (k_q > s) ? (k_q - s) : '0;
    accept   = trig && !abort;

    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    lat_i_d = lat_i_q;
    lat_q_d = lat_q_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        k_d = '0;
        if (accept) begin
          lat_i_d = set_i;
          lat_q_d = set_q;
          k_d     = s;
          state_d = S_RISE;
        end
      end
      S_RISE: begin
        if (abort) begin
          state_d = S_FALL;
        end else begin
          k_d = k_up_sat;
          if (k_up_sat == K_ONE) begin
            state_d = S_FLAT;
            cnt_d   = hold_len;
          end
        end
      end
      S_FLAT: begin
        if (abort || cnt_q == '0) state_d = S_FALL;
        else                      cnt_d   = cnt_q - 1'b1;
      end
      S_FALL: begin
        // Re-trigger resumes the rise from the current k so the envelope stays continuous.
        if (accept) begin
          lat_i_d = set_i;
          lat_q_d = set_q;
          k_d     = k_up_sat;
          state_d = S_RISE;
        end else begin
          k_d = k_dn_sat;
          if (k_dn_sat == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    p_i_d     = PW'(lat_i_q) * PW'($signed({1'b0, k_q}));
    p_q_d     = PW'(lat_q_q) * PW'($signed({1'b0, k_q}));
    drive_i_d = p_i_q[DW+15:16];
    drive_q_d = p_q_q[DW+15:16];
  end

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      lat_i_q   <= '0;
      lat_q_q   <= '0;
      p_i_q     <= '0;
      p_q_q     <= '0;
      drive_i_q <= '0;
      drive_q_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      lat_i_q   <= lat_i_d;
      lat_q_q   <= lat_q_d;
      p_i_q     <= p_i_d;
      p_q_q     <= p_q_d;
      drive_i_q <= drive_i_d;
      drive_q_q <= drive_q_d;
      done_q    <= done_d;
    end
  end

  assign drive_i = drive_i_q;
  assign drive_q = drive_q_q;
  assign state   = state_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule
